// File: rtl/nonce_pkg.sv
// Shared nonce search constants and FSM state encoding for the nonce register slice.
package nonce_pkg;
   localparam int NONCE_W = 256;
   localparam int LOAD_N  = NONCE_W / 8;
   localparam int COUNT_W = 32;
   localparam int IDX_W   = $clog2(LOAD_N);

   localparam logic [NONCE_W-1:0] NONCE_ALL_ONES = '1;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE      = 2'd0;
   localparam state_t ST_LOAD      = 2'd1;
   localparam state_t ST_RUN       = 2'd2;
   localparam state_t ST_EXHAUSTED = 2'd3;
endpackage

// File: rtl/nonce_register_if.sv
// Host seed link plus nonce hand-off to the hash cores.
// issued_count only exists when NONCE_COUNT_EN is defined.
interface nonce_register_if;
   import nonce_pkg::*;

   logic               load_valid;
   logic [7:0]         load_byte;
   logic [NONCE_W-1:0] nonce;
   logic               nonce_valid;
   logic               nonce_ready;
   logic               loading;
   logic               exhausted;
`ifdef NONCE_COUNT_EN
   logic [COUNT_W-1:0] issued_count;
`endif

   modport master (
      output load_valid, load_byte, nonce_ready,
`ifdef NONCE_COUNT_EN
      input  issued_count,
`endif
      input  nonce, nonce_valid, loading, exhausted
   );

   modport slave (
      input  load_valid, load_byte, nonce_ready,
`ifdef NONCE_COUNT_EN
      output issued_count,
`endif
      output nonce, nonce_valid, loading, exhausted
   );
endinterface

// File: rtl/nonce_increment.sv
// Combinational +1 on the 256-bit nonce, built as a byte-wide carry chain.
module nonce_increment
   import nonce_pkg::*;
(
   input  logic [NONCE_W-1:0] value,
   output logic [NONCE_W-1:0] incremented
);
   logic [LOAD_N-1:0] carry;

   assign carry[0] = 1'b1;

   for (genvar k = 0; k < LOAD_N - 1; k++) begin : g_byte
      assign {carry[k+1], incremented[8*k +: 8]} = {1'b0, value[8*k +: 8]} + 9'(carry[k]);
   end

   // Top byte drops its carry-out: the all-ones nonce is never advanced.
   assign incremented[NONCE_W-1 -: 8] = value[NONCE_W-1 -: 8] + 8'(carry[LOAD_N-1]);
endmodule

// File: rtl/nonce_register.sv
// Working nonce register: byte-serial seed load, one nonce per handshake, exhaustion flag.
// Optional issued-nonce counter enabled by defining NONCE_COUNT_EN.
//
// state        | meaning
// ST_IDLE      | after reset, nothing loaded, no nonce offered
// ST_LOAD      | seed bytes being written, LSB byte first
// ST_RUN       | nonce offered, advances on each accept
// ST_EXHAUSTED | all-ones nonce issued, waiting for a new seed
module nonce_register
   import nonce_pkg::*;
(
   input logic             clk,
   input logic             rst,
   nonce_register_if.slave bus
);
   state_t             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [NONCE_W-1:0] nonce_q;
   logic [NONCE_W-1:0] nonce_inc;
   logic               accept;
   logic               load_start;

   // A seed byte always beats a simultaneous handshake.
   assign accept     = (state_q == ST_RUN) && bus.nonce_ready && !bus.load_valid;
   assign load_start = bus.load_valid && (state_q != ST_LOAD);

   nonce_increment u_inc (
      .value       (nonce_q),
      .incremented (nonce_inc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         nonce_q <= '0;
      end else if (load_start) begin
         nonce_q[7:0] <= bus.load_byte;
         idx_q        <= IDX_W'(1);
         state_q      <= ST_LOAD;
      end else if (bus.load_valid) begin
         nonce_q[{idx_q, 3'b000} +: 8] <= bus.load_byte;
         idx_q                         <= idx_q + IDX_W'(1);
         if (idx_q == IDX_W'(LOAD_N - 1))
            state_q <= ST_RUN;
      end else if (accept) begin
         if (nonce_q == NONCE_ALL_ONES)
            state_q <= ST_EXHAUSTED;
         else
            nonce_q <= nonce_inc;
      end
   end

`ifdef NONCE_COUNT_EN
   logic [COUNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_q <= '0;
      else if (load_start)
         count_q <= '0;
      else if (accept && (count_q != '1))
         count_q <= count_q + COUNT_W'(1);
   end

   assign bus.issued_count = count_q;
`endif

   assign bus.nonce       = nonce_q;
   assign bus.nonce_valid = (state_q == ST_RUN);
   assign bus.loading     = (state_q == ST_LOAD);
   assign bus.exhausted   = (state_q == ST_EXHAUSTED);
endmodule

// File: tb/tb_nonce_register.sv
// Directed bench for nonce_register: accepted nonces are checked by a scoreboard monitor.
module tb_nonce_register;
   import nonce_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [NONCE_W-1:0] exp_q[$];

   localparam logic [NONCE_W-1:0] SEED_RAMP =
      256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;

   nonce_register_if bus();

   nonce_register dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [NONCE_W-1:0] act,
                        input logic [NONCE_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_seed(input logic [NONCE_W-1:0] seed);
      for (int k = 0; k < LOAD_N; k++) begin
         bus.load_valid = 1'b1;
         bus.load_byte  = seed[8*k +: 8];
         tick();
      end
      bus.load_valid = 1'b0;
   endtask

   // Scoreboard monitor: every real accept must match the next queued nonce.
   always @(negedge clk) begin
      if (!rst && bus.nonce_valid && bus.nonce_ready && !bus.load_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL accept_unexpected: got %h expected none", bus.nonce);
         end else begin
            logic [NONCE_W-1:0] e;
            e = exp_q.pop_front();
            if (bus.nonce !== e) begin
               n_err++;
               $display("FAIL accept_nonce: got %h expected %h", bus.nonce, e);
            end
         end
      end
   end

   initial begin
      logic [NONCE_W-1:0] v;
      rst            = 1'b1;
      bus.load_valid = 1'b0;
      bus.load_byte  = 8'h00;
      bus.nonce_ready = 1'b1;
      repeat (3) tick();
      check("rst_nonce", bus.nonce, '0);
      check("rst_valid", 256'(bus.nonce_valid), 256'd0);
      check("rst_loading", 256'(bus.loading), 256'd0);
      check("rst_exhausted", 256'(bus.exhausted), 256'd0);
`ifdef NONCE_COUNT_EN
      check("rst_count", 256'(bus.issued_count), 256'd0);
`endif
      rst = 1'b0;
      tick();
      check("idle_ready_ignored", bus.nonce, '0);
      bus.nonce_ready = 1'b0;

      // Ramp seed, valid must rise only after the last byte.
      for (int k = 0; k < LOAD_N; k++) begin
         bus.load_valid = 1'b1;
         bus.load_byte  = 8'(k);
         if (k == 16) check("mid_load_loading", 256'(bus.loading), 256'd1);
         if (k == 31) check("last_byte_valid_low", 256'(bus.nonce_valid), 256'd0);
         tick();
      end
      bus.load_valid = 1'b0;
      check("ramp_valid", 256'(bus.nonce_valid), 256'd1);
      check("ramp_loading", 256'(bus.loading), 256'd0);
      check("ramp_nonce", bus.nonce, SEED_RAMP);

      // Back-to-back accepts from 0xFF across a byte carry.
      load_seed(256'h00ff);
      exp_q.push_back(256'h00ff);
      exp_q.push_back(256'h0100);
      exp_q.push_back(256'h0101);
      exp_q.push_back(256'h0102);
      exp_q.push_back(256'h0103);
      bus.nonce_ready = 1'b1;
      repeat (5) tick();
      bus.nonce_ready = 1'b0;
      check("b2b_next", bus.nonce, 256'h0104);
      check("b2b_valid", 256'(bus.nonce_valid), 256'd1);
`ifdef NONCE_COUNT_EN
      check("count_five", 256'(bus.issued_count), 256'd5);
`endif

      // Full carry chain into the top byte.
      v = {8'h00, {31{8'hff}}};
      load_seed(v);
      exp_q.push_back(v);
      bus.nonce_ready = 1'b1;
      tick();
      bus.nonce_ready = 1'b0;
      check("carry_chain", bus.nonce, 256'd1 << 248);
`ifdef NONCE_COUNT_EN
      check("count_cleared_by_load", 256'(bus.issued_count), 256'd1);
`endif

      // Exhaustion on the all-ones nonce.
      load_seed(NONCE_ALL_ONES);
      exp_q.push_back(NONCE_ALL_ONES);
      bus.nonce_ready = 1'b1;
      tick();
      check("exh_valid", 256'(bus.nonce_valid), 256'd0);
      check("exh_flag", 256'(bus.exhausted), 256'd1);
      check("exh_nonce", bus.nonce, NONCE_ALL_ONES);
`ifdef NONCE_COUNT_EN
      check("exh_count", 256'(bus.issued_count), 256'd1);
`endif
      tick();
      check("exh_sticky", 256'(bus.exhausted), 256'd1);
      check("exh_no_wrap", bus.nonce, NONCE_ALL_ONES);
      bus.nonce_ready = 1'b0;
      bus.load_valid  = 1'b1;
      bus.load_byte   = 8'h5a;
      tick();
      bus.load_valid  = 1'b0;
      check("reload_exh_clear", 256'(bus.exhausted), 256'd0);
      check("reload_loading", 256'(bus.loading), 256'd1);
      check("reload_partial", bus.nonce, {{31{8'hff}}, 8'h5a});
`ifdef NONCE_COUNT_EN
      check("reload_count_clear", 256'(bus.issued_count), 256'd0);
`endif
      for (int k = 1; k < LOAD_N; k++) begin
         bus.load_valid = 1'b1;
         bus.load_byte  = 8'h00;
         tick();
      end
      bus.load_valid = 1'b0;
      check("reload_done", bus.nonce, 256'h5a);

      // Stall: ready low holds everything.
      for (int c = 0; c < 10; c++) begin
         tick();
         check("stall_nonce", bus.nonce, 256'h5a);
         check("stall_valid", 256'(bus.nonce_valid), 256'd1);
      end
      // Load byte with ready high: load wins, no increment.
      bus.load_valid  = 1'b1;
      bus.load_byte   = 8'h77;
      bus.nonce_ready = 1'b1;
      tick();
      bus.load_valid  = 1'b0;
      bus.nonce_ready = 1'b0;
      check("abort_valid", 256'(bus.nonce_valid), 256'd0);
      check("abort_loading", 256'(bus.loading), 256'd1);
      check("abort_nonce", bus.nonce, 256'h77);

      // Async reset mid-load.
      bus.load_valid = 1'b1;
      bus.load_byte  = 8'h11;
      tick();
      bus.load_byte  = 8'h22;
      tick();
      bus.load_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_nonce", bus.nonce, '0);
      check("arst_loading", 256'(bus.loading), 256'd0);
      check("arst_valid", 256'(bus.nonce_valid), 256'd0);
`ifdef NONCE_COUNT_EN
      check("arst_count", 256'(bus.issued_count), 256'd0);
`endif
      tick();
      rst = 1'b0;
      tick();
      load_seed(SEED_RAMP);
      check("post_rst_seed", bus.nonce, SEED_RAMP);

      check("scoreboard_drain", 256'(exp_q.size()), 256'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
